// File: rtl/pipe_add_sub_pkg.sv
// Shared constants and the per-stage record for the segmented add/sub pipeline.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package pipe_add_sub_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

  // Control bits that ride along with each pipeline slot.
  //   valid : slot holds a live operation
  //   sub   : operation is a subtract (kept for the slot's lifetime)
  //   carry : carry out of the most recently completed segment
  //   cmsb  : carry into the top bit of the most recently completed segment
  //   a_msb : sign of operand a, needed to pick the saturation direction
  typedef struct packed {
    logic valid;
    logic sub;
    logic carry;
    logic cmsb;
    logic a_msb;
  } stage_ctl_t;

  // Full per-stage record at the default width. The partial sum fills from
  // the top as segments complete; the remaining operand bits drain from the
  // bottom, so the next segment to add always sits at bit 0.
  typedef struct packed {
    stage_ctl_t                 ctl;
    logic [DEF_WIDTH-1:0]       part;
    logic [DEF_WIDTH-1:0]       a_rem;
    logic [DEF_WIDTH-1:0]       b_rem;
  } stage_rec_t;

  // Number of pipeline stages for a given width / segment size.
  function automatic int stage_count(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/pipe_add_sub_seg_adder.sv
// Combinational SEG-bit ripple-carry adder used by every pipeline stage.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage register decides when to capture.
module seg_adder #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_ci,
  output logic [SEG-1:0] o_s,
  output logic           o_co,
  output logic           o_cmsb
);

  logic [SEG:0] w_c;

  // Chain of full adders; w_c[i] is the carry into bit i.
  always_comb begin
    w_c    = '0;
    o_s    = '0;
    w_c[0] = i_ci;
    for (int i = 0; i < SEG; i++) begin
      o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_co   = w_c[SEG];
  assign o_cmsb = w_c[SEG-1];

endmodule

// File: rtl/pipe_add_sub.sv
// Segmented pipelined add/subtract with carry, signed overflow and optional saturation (PIPE_ADD_SUB_SAT_EN).
// Latency: WIDTH/SEG cycles from acceptance to out_valid; one result per cycle when not stalled.
// Backpressure: whole pipe freezes when out_valid=1 and out_ready=0; in_ready mirrors the advance enable.
module pipe_add_sub
  import pipe_add_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = stage_count(WIDTH, SEG);

  if ((WIDTH % SEG) != 0 || STAGES < 1) begin : g_bad_cfg
    $error("pipe_add_sub: WIDTH must be a positive multiple of SEG");
  end

  // Same layout as stage_rec_t, sized for this instance's WIDTH.
  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
  } rec_t;

  rec_t r_pipe [STAGES];
  rec_t w_last;
  logic w_adv;
  logic w_ovf;

  assign w_last = r_pipe[STAGES-1];

  // The pipe moves as a single unit: it advances whenever the output slot is
  // empty or being drained this cycle, so bubbles are squeezed only at the end.
  assign w_adv    = out_ready | ~w_last.ctl.valid;
  assign in_ready = w_adv;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    rec_t                 w_d;
    rec_t                 w_nxt;
    logic [SEG-1:0]       w_s;
    logic                 w_co;
    logic                 w_cmsb;
    logic [WIDTH+SEG-1:0] w_cat;

    if (k == 0) begin : g_head
      // Load a fresh slot: subtract is a + ~b + ~cin, so invert b and cin here
      // and let every later stage treat the op as a plain add.
      always_comb begin
        w_d           = '0;
        w_d.ctl.valid = in_valid;
        w_d.ctl.sub   = sub;
        w_d.ctl.carry = cin ^ sub;
        w_d.ctl.a_msb = a[WIDTH-1];
        w_d.a_rem     = a;
        w_d.b_rem     = b ^ {WIDTH{sub}};
      end
    end else begin : g_body
      assign w_d = r_pipe[k-1];
    end

    seg_adder #(
      .SEG (SEG)
    ) u_seg (
      .i_a    (w_d.a_rem[SEG-1:0]),
      .i_b    (w_d.b_rem[SEG-1:0]),
      .i_ci   (w_d.ctl.carry),
      .o_s    (w_s),
      .o_co   (w_co),
      .o_cmsb (w_cmsb)
    );

    // New segment enters at the top of the partial sum; after the last stage
    // the segments have shifted down into their final bit positions.
    assign w_cat = {w_s, w_d.part};

    // Next slot contents: consumed operand segment drops off the bottom.
    always_comb begin
      w_nxt           = w_d;
      w_nxt.ctl.carry = w_co;
      w_nxt.ctl.cmsb  = w_cmsb;
      w_nxt.part      = WIDTH'(w_cat >> SEG);
      w_nxt.a_rem     = w_d.a_rem >> SEG;
      w_nxt.b_rem     = w_d.b_rem >> SEG;
    end

    // Stage register: reset clears everything, otherwise capture only on advance.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_pipe[k] <= '0;
      end else if (w_adv) begin
        r_pipe[k] <= w_nxt;
      end
    end
  end

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign w_ovf     = w_last.ctl.carry ^ w_last.ctl.cmsb;
  assign out_valid = w_last.ctl.valid;
  assign cout      = w_last.ctl.carry;
  assign ovf       = w_ovf;

`ifdef PIPE_ADD_SUB_SAT_EN
  // Clamp toward the sign of a: positive overflow -> max, negative -> min.
  assign sum = w_ovf ? {w_last.ctl.a_msb, {(WIDTH-1){~w_last.ctl.a_msb}}}
                     : w_last.part;
`else
  assign sum = w_last.part;
`endif

endmodule

// File: tb/tb_pipe_add_sub.sv
// Scoreboard bench for pipe_add_sub at WIDTH=8, SEG=4 (two stages).
// Directed cases for reset, carry, overflow, subtract, stall and flush, then random traffic.
// Expected results come from a plain-arithmetic model queued at acceptance.
module tb_pipe_add_sub;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  res_t exp_q[$];

  pipe_add_sub #(
    .WIDTH (W),
    .SEG   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
    end
  endtask

  // Reference: integer arithmetic on the operand values.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mci, input logic msub);
    res_t r;
    int   sa, sb, ua, ub, ci, sres;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    ua = int'(ma);
    ub = int'(mb);
    ci = mci ? 1 : 0;
    if (!msub) begin
      sres = sa + sb + ci;
      r.c  = (ua + ub + ci) > 255;
      r.s  = W'(ua + ub + ci);
    end else begin
      sres = sa - sb - ci;
      r.c  = ua >= (ub + ci);
      r.s  = W'(ua - ub - ci);
    end
    r.v = (sres > 127) || (sres < -128);
`ifdef PIPE_ADD_SUB_SAT_EN
    if (r.v) r.s = ma[W-1] ? 8'h80 : 8'h7F;
`endif
    return r;
  endfunction

  // Monitor: retire outputs against the queue, enqueue accepted inputs,
  // and confirm that a stalled output holds its value.
  logic         hold_prev = 1'b0;
  logic [W+2:0] hold_val  = '0;
  always @(negedge clk) begin
    if (hold_prev) begin
      check("hold", {29'd0, out_valid, sum, cout, ovf} , {29'd0, 1'b1, hold_val[W+1:0]});
    end
    hold_prev = (rst === 1'b0) && (out_valid === 1'b1) && (out_ready === 1'b0);
    hold_val  = {1'b0, sum, cout, ovf};
    if (rst === 1'b1) begin
      exp_q.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {23'd0, sum, cout}, 32'hDEAD);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("sb", {22'd0, sum, cout, ovf}, {22'd0, e.s, e.c, e.v});
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tci, input logic tsub);
    in_valid = 1'b1;
    a   = ta;
    b   = tb;
    cin = tci;
    sub = tsub;
  endtask

  task automatic drain(input string name);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      cycle();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Single op into an empty pipe; checks the result exactly two edges later.
  task automatic dir_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tci, input logic tsub,
                        input logic [W-1:0] es, input logic ec, input logic ev);
    out_ready = 1'b1;
    set_op(ta, tb, tci, tsub);
    cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_early"}, out_valid, 0);
    cycle();
    @(negedge clk);
    check(name, {21'd0, out_valid, sum, cout, ovf}, {21'd0, 1'b1, es, ec, ev});
    cycle();
  endtask

  initial begin
    logic [W-1:0] sat_exp;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    cycle();

    dir_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
`ifdef PIPE_ADD_SUB_SAT_EN
    sat_exp = 8'h7F;
`else
    sat_exp = 8'h80;
`endif
    dir_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, sat_exp, 1'b0, 1'b1);
    dir_op("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    dir_op("sub_20_10_b", 8'h20, 8'h10, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0);
    dir_op("add_cin", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);
    drain("drain_dir");

    // Three back-to-back ops with the consumer stalled.
    out_ready = 1'b0;
    set_op(8'h11, 8'h22, 1'b0, 1'b0); cycle();
    set_op(8'h50, 8'h05, 1'b0, 1'b1); cycle();
    set_op(8'hF0, 8'h20, 1'b0, 1'b0); cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("stall_in_ready_0", in_ready, 0);
    check("stall_first", {23'd0, out_valid, sum}, {23'd0, 1'b1, 8'h33});
    cycle();
    @(negedge clk);
    check("stall_in_ready_1", in_ready, 0);
    check("stall_held", sum, 8'h33);
    cycle();
    drain("drain_stall");

    // Reset with two ops in flight: neither may emerge.
    out_ready = 1'b1;
    set_op(8'h01, 8'h02, 1'b0, 1'b0); cycle();
    set_op(8'h03, 8'h04, 1'b0, 1'b0); cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_out_valid", out_valid, 0);
      cycle();
    end

    // Random traffic with random backpressure and mixed modes.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain("drain_rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
